prog_timer: RTL and testbench

//  Runtime-programmable successor to the fixed-terminal timer: counts prescaled ticks from 0 up to a

---
 rtl/prog_timer_pkg.sv | 6 +
 rtl/prog_timer_tick_gen.sv | 21 ++
 rtl/prog_timer.sv | 79 +++++++
 tb/tb_prog_timer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/prog_timer_pkg.sv
// prog_timer_pkg: shared state encodings and mode constants for the programmable timer
package prog_timer_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;
endpackage

// File: rtl/prog_timer_tick_gen.sv
// tick_gen: prescaler emitting a one-cycle tick every div+1 enabled clocks
module tick_gen #(
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] div,
    output logic             tick
);
    logic [PRE_W-1:0] pre_q, pre_d;
    always_comb begin
        tick  = en && (pre_q == div);
        pre_d = (clr || tick) ? '0 : en ? pre_q + 1'b1 : pre_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pre_q <= '0;
        else        pre_q <= pre_d;
    end
endmodule

// File: rtl/prog_timer.sv
// prog_timer: runtime-programmable one-shot / auto-reload tick counter with done pulse
module prog_timer
    import prog_timer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_val,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d, load_q, load_d;
    logic [PRE_W-1:0] pre_l_q, pre_l_d;
    logic             mode_q, mode_d, done_q, done_d, tick, run;
    assign run = (state_q == ST_RUN);
    tick_gen #(.PRE_W(PRE_W)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (run && enable),
        .clr   (start || stop),
        .div   (pre_l_q),
        .tick  (tick)
    );
    // stop outranks start, and both outrank a coincident terminal tick
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load_d  = load_q;
        pre_l_d = pre_l_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = ST_RUN;
            count_d = '0;
            load_d  = load_val;
            pre_l_d = prescale;
            mode_d  = mode;
        end else if (run && tick) begin
            if (count_q == load_q) begin
                done_d  = 1'b1;
                count_d = (mode_q == MODE_RELOAD) ? '0 : count_q;
                state_d = (mode_q == MODE_RELOAD) ? ST_RUN : ST_IDLE;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            load_q  <= '0;
            pre_l_q <= '0;
            mode_q  <= MODE_ONESHOT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            load_q  <= load_d;
            pre_l_q <= pre_l_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end
    assign count = count_q;
    assign busy  = run;
    assign done  = done_q;
endmodule

// File: tb/tb_prog_timer.sv
// tb_prog_timer: directed self-checking bench for prog_timer
module tb_prog_timer;
    logic       clk, reset, enable, start, stop, mode;
    logic [7:0] load_val, count;
    logic [3:0] prescale;
    logic       busy, done;
    int         checks = 0;
    int         errors = 0;
    int         n, pulses, first_gap;

    prog_timer #(.WIDTH(8), .PRE_W(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .stop(stop),
        .mode(mode), .load_val(load_val), .prescale(prescale),
        .count(count), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic m, input int ld, input int ps);
        mode = m;
        load_val = 8'(ld);
        prescale = 4'(ps);
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cnt);
        cnt = 0;
        do begin
            step(1);
            cnt++;
        end while (!done && cnt <= max);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; start = 1'b1; stop = 1'b0;
        mode = 1'b0; load_val = 8'd0; prescale = 4'd0;
        step(3);
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        start = 1'b0;
        reset = 1'b1;
        step(3);
        chk("post_rst_busy", int'(busy), 0);

        do_start(1'b0, 5, 0);
        chk("os_busy_start", int'(busy), 1);
        wait_done(20, n);
        chk("os_latency", n, 6);
        chk("os_count", int'(count), 5);
        chk("os_busy_fall", int'(busy), 0);
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            pulses += int'(done);
        end
        chk("os_no_more_done", pulses, 0);

        do_start(1'b1, 3, 2);
        wait_done(40, n);
        chk("per_first", n, 12);
        pulses = 0;
        first_gap = 0;
        for (int i = 1; i <= 48; i++) begin
            step(1);
            if (done) begin
                pulses++;
                if (first_gap == 0) first_gap = i;
            end
        end
        chk("per_pulses", pulses, 4);
        chk("per_gap", first_gap, 12);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("per_stop_busy", int'(busy), 0);

        do_start(1'b0, 9, 0);
        step(4);
        chk("pause_count4", int'(count), 4);
        enable = 1'b0;
        step(7);
        chk("pause_hold", int'(count), 4);
        chk("pause_busy", int'(busy), 1);
        enable = 1'b1;
        wait_done(40, n);
        chk("pause_total", 11 + n, 17);

        do_start(1'b0, 2, 0);
        step(2);
        chk("race_pre_count", int'(count), 2);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("race_stop_done", int'(done), 0);
        chk("race_stop_busy", int'(busy), 0);
        chk("race_stop_count", int'(count), 2);
        step(1);
        chk("race_stop_done2", int'(done), 0);

        do_start(1'b0, 5, 0);
        step(2);
        start = 1'b1;
        stop = 1'b1;
        step(1);
        start = 1'b0;
        stop = 1'b0;
        chk("race_both_busy", int'(busy), 0);
        chk("race_both_count", int'(count), 2);

        do_start(1'b0, 5, 0);
        step(2);
        chk("rs_pre_count", int'(count), 2);
        do_start(1'b0, 1, 0);
        load_val = 8'd200;
        chk("rs_count0", int'(count), 0);
        chk("rs_no_done", int'(done), 0);
        wait_done(20, n);
        chk("rs_latency", n, 2);
        chk("rs_count", int'(count), 1);

        do_start(1'b1, 0, 0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            pulses += int'(done);
        end
        chk("l0_pulses", pulses, 5);
        chk("l0_count", int'(count), 0);
        stop = 1'b1;
        step(1);
        stop = 1'b0;

        do_start(1'b0, 255, 15);
        wait_done(5000, n);
        chk("max_latency", n, 4096);
        chk("max_count", int'(count), 255);

        do_start(1'b1, 200, 0);
        step(100);
        chk("ar_pre_count", int'(count), 100);
        #2 reset = 1'b0;
        #1;
        chk("ar_count", int'(count), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_done", int'(done), 0);
        step(2);
        reset = 1'b1;
        step(2);
        chk("ar_idle", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
